// File: rtl/axil_regbank_v2.sv
// AXI4-Lite slave register bank with a configurable number and width of
// registers. The low indices are read/write control registers; the top
// C_NUM_RO indices are read-only and reflect status_in. Writes honour WSTRB,
// raise a one-cycle wr_pulse for the written register, and return SLVERR for
// read-only or unimplemented indices.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where VALID and READY are both high. A master holds VALID and its payload
// until that edge. This slave never takes back a READY it has raised before
// the transfer, and holds B/R VALID with a stable payload until the transfer.
module axil_regbank_v2 #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_NUM_REGS         = 16,
  parameter int C_NUM_RO           = 2
) (
  input  logic                                         S_AXI_ACLK,
  input  logic                                         S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
  input  logic [2:0]                                   S_AXI_AWPROT,
  input  logic                                         S_AXI_AWVALID,
  output logic                                         S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
  input  logic                                         S_AXI_WVALID,
  output logic                                         S_AXI_WREADY,
  output logic [1:0]                                   S_AXI_BRESP,
  output logic                                         S_AXI_BVALID,
  input  logic                                         S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
  input  logic [2:0]                                   S_AXI_ARPROT,
  input  logic                                         S_AXI_ARVALID,
  output logic                                         S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
  output logic [1:0]                                   S_AXI_RRESP,
  output logic                                         S_AXI_RVALID,
  input  logic                                         S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]     reg_out,
  input  logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [C_NUM_REGS-1:0]                        wr_pulse
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int STRB_W   = DW / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = AW - ADDR_LSB;
  localparam int NUM_RW   = C_NUM_REGS - C_NUM_RO;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_e;
  typedef enum logic       {RD_IDLE, RD_DATA}            rd_state_e;

  // Write path state
  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [C_NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic                  aw_hs, w_hs;

  // Read path state
  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [IDX_W-1:0]      rd_idx;
  logic [DW-1:0]         rd_val;
  logic                  rd_err;

  // Control register storage
  logic [DW-1:0]         regs_q [NUM_RW];
  logic [DW-1:0]         regs_d [NUM_RW];

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  function automatic logic idx_is_rw(input logic [IDX_W-1:0] idx);
    return int'(idx) < NUM_RW;
  endfunction

  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID && wready_q;

  // Write FSM: collect AW and W independently, commit once, then respond.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = S_AXI_AWADDR[AW-1:ADDR_LSB];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if (aw_held_d && w_held_d) begin
          wr_state_d = WR_COMMIT;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          // The pulse is registered here so it is high exactly during COMMIT.
          for (int i = 0; i < C_NUM_REGS; i++) begin
            wr_pulse_d[i] = idx_is_rw(aw_idx_d) && (int'(aw_idx_d) == i);
          end
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      WR_COMMIT: begin
        wr_state_d = WR_RESP;
        bvalid_d   = 1'b1;
        bresp_d    = idx_is_rw(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
      end
      WR_RESP: begin
        if (S_AXI_BREADY) begin
          wr_state_d = WR_IDLE;
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Register update: byte lanes selected by the captured strobe, during COMMIT only.
  always_comb begin
    for (int r = 0; r < NUM_RW; r++) begin
      regs_d[r] = regs_q[r];
      if ((wr_state_q == WR_COMMIT) && (int'(aw_idx_q) == r)) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_q[b]) begin
            regs_d[r][b*8 +: 8] = wdata_q[b*8 +: 8];
          end
        end
      end
    end
  end

  // Write path and register storage flops.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int r = 0; r < NUM_RW; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int r = 0; r < NUM_RW; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Read decode: value as it stands this cycle, so a read during COMMIT sees the old data.
  always_comb begin
    rd_idx = S_AXI_ARADDR[AW-1:ADDR_LSB];
    rd_val = '0;
    rd_err = 1'b1;
    for (int r = 0; r < NUM_RW; r++) begin
      if (int'(rd_idx) == r) begin
        rd_val = regs_q[r];
        rd_err = 1'b0;
      end
    end
    for (int s = 0; s < C_NUM_RO; s++) begin
      if (int'(rd_idx) == NUM_RW + s) begin
        rd_val = status_in[s*DW +: DW];
        rd_err = 1'b0;
      end
    end
  end

  // Read FSM: accept one address, present the data until it is taken.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          rd_state_d = RD_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_val;
          rresp_d    = rd_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      RD_DATA: begin
        if (S_AXI_RREADY) begin
          rd_state_d = RD_IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read path flops.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Flattened register view; read-only slots pass status_in straight through.
  always_comb begin
    reg_out = '0;
    for (int r = 0; r < NUM_RW; r++) begin
      reg_out[r*DW +: DW] = regs_q[r];
    end
    for (int s = 0; s < C_NUM_RO; s++) begin
      reg_out[(NUM_RW+s)*DW +: DW] = status_in[s*DW +: DW];
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axil_regbank_v2.sv
// Bench for axil_regbank_v2 with 15 registers, the top two read-only, so
// index 15 (byte address 0x3C) is unimplemented.
module tb_axil_regbank_v2;

  localparam int NUM_REGS = 15;
  localparam int NUM_RO   = 2;
  localparam int NUM_RW   = NUM_REGS - NUM_RO;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [5:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [NUM_REGS*32-1:0] reg_out;
  logic [NUM_RO*32-1:0]   status_in = '0;
  logic [NUM_REGS-1:0]    wr_pulse;

  // Scoreboard queues and reference model
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [3:0]  exp_p_q[$];
  logic [31:0] model_regs [NUM_RW];
  int checks = 0;
  int errors = 0;

  axil_regbank_v2 #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6),
    .C_NUM_REGS(NUM_REGS), .C_NUM_RO(NUM_RO)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h req=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s act=event req=none t=%0t", name, $time);
  endtask

  // Reference model: expected read response for a byte address
  function automatic logic [33:0] model_read(input logic [5:0] addr);
    int idx;
    idx = int'(addr) / 4;
    if (idx < NUM_RW) return {model_regs[idx], OKAY};
    if (idx < NUM_REGS) return {status_in[(idx-NUM_RW)*32 +: 32], OKAY};
    return {32'h0, SLVERR};
  endfunction

  function automatic logic [31:0] model_slot(input int idx);
    if (idx < NUM_RW) return model_regs[idx];
    return status_in[(idx-NUM_RW)*32 +: 32];
  endfunction

  // Monitor: pops the expected queues whenever the DUT completes a response or pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) fail_now("b_unexpected");
        else chk("bresp", 64'(bresp), 64'(exp_b_q.pop_front()));
      end
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) fail_now("r_unexpected");
        else chk("rdata_rresp", 64'({rdata, rresp}), 64'(exp_r_q.pop_front()));
      end
      if (wr_pulse != '0) begin
        if (exp_p_q.size() == 0) fail_now("pulse_unexpected");
        else chk("wr_pulse", 64'(wr_pulse), 64'(1) << exp_p_q.pop_front());
      end
    end
  end

  // Write driver: AW and W raised after their own delays, then B held off b_dly cycles
  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int idx, cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [1:0] exp_resp;
    idx = int'(addr) / 4;
    if (idx < NUM_RW) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
      exp_p_q.push_back(4'(idx));
      exp_resp = OKAY;
    end else begin
      exp_resp = SLVERR;
    end
    exp_b_q.push_back(exp_resp);
    awaddr = addr; wdata = data; wstrb = strb;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 100) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if (aw_done && !w_done) begin
        chk("aw_ready_after_capture", 64'(awready), 64'(0));
        chk("w_ready_waiting", 64'(wready), 64'(1));
      end
      if (w_done && !aw_done) begin
        chk("w_ready_after_capture", 64'(wready), 64'(0));
        chk("aw_ready_waiting", 64'(awready), 64'(1));
      end
      @(posedge clk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) begin
      fail_now("write_addr_data_timeout");
      return;
    end
    @(negedge clk);
    chk("b_not_early", 64'(bvalid), 64'(0));
    @(posedge clk); #1;
    for (int k = 0; k < b_dly; k++) begin
      @(negedge clk);
      chk("b_held", 64'(bvalid), 64'(1));
      chk("bresp_stable", 64'(bresp), 64'(exp_resp));
      chk("aw_blocked_in_resp", 64'(awready), 64'(0));
      @(posedge clk); #1;
    end
    bready = 1;
    @(negedge clk);
    chk("b_valid", 64'(bvalid), 64'(1));
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    chk("b_dropped", 64'(bvalid), 64'(0));
    chk("readys_rearm", 64'({awready, wready}), 64'(2'b11));
    @(posedge clk); #1;
  endtask

  // Read driver: AR after ar_dly cycles, R held off r_dly cycles
  task automatic do_read(input logic [5:0] addr, input int ar_dly, input int r_dly);
    logic [33:0] exp;
    bit done, hs;
    int cyc;
    exp = model_read(addr);
    exp_r_q.push_back(exp);
    araddr = addr;
    repeat (ar_dly) begin @(posedge clk); #1; end
    done = 0; cyc = 0;
    while (!done && cyc < 100) begin
      arvalid = 1;
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) done = 1;
      cyc++;
    end
    arvalid = 0;
    if (!done) begin
      fail_now("read_addr_timeout");
      return;
    end
    for (int k = 0; k < r_dly; k++) begin
      @(negedge clk);
      chk("r_held", 64'(rvalid), 64'(1));
      chk("rdata_stable", 64'({rdata, rresp}), 64'(exp));
      chk("ar_blocked", 64'(arready), 64'(0));
      @(posedge clk); #1;
    end
    rready = 1;
    @(negedge clk);
    chk("r_valid", 64'(rvalid), 64'(1));
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    chk("r_dropped", 64'(rvalid), 64'(0));
    chk("ar_rearm", 64'(arready), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < NUM_RW; r++) model_regs[r] = '0;
  endtask

  // Main stimulus
  initial begin
    int op, ad, aw_d, w_d, bd;
    bit hs_aw, hs_w;
    clear_model();
    status_in = {32'hDEADBEEF, 32'h0BAD_F00D};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_readys", 64'({awready, wready, arready}), 64'(0));
    chk("rst_valids", 64'({bvalid, rvalid}), 64'(0));
    chk("rst_resp_data", 64'({rdata, bresp, rresp}), 64'(0));
    chk("rst_pulse", 64'(wr_pulse), 64'(0));
    for (int r = 0; r < NUM_RW; r++) chk("rst_reg", 64'(reg_out[r*32 +: 32]), 64'(0));
    rst_n = 1;
    #1 chk("readys_before_edge", 64'({awready, wready, arready}), 64'(0));
    @(posedge clk); #1;
    chk("readys_after_edge", 64'({awready, wready, arready}), 64'(3'b111));

    // Four writes, read back
    for (int i = 0; i < 4; i++) do_write(6'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(6'(i*4), 0, 0);

    // Byte strobes
    do_write(6'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_write(6'h00, 32'h1234_5678, 4'b0101, 0, 0, 0);
    do_read(6'h00, 0, 0);
    chk("strobe_merge_model", 64'(reg_out[31:0]), 64'(32'hFF34_FF78));

    // AW three cycles ahead of W, and W ahead of AW
    do_write(6'h08, 32'h0000_00A5, 4'hF, 0, 3, 0);
    do_read(6'h08, 0, 0);
    do_write(6'h14, 32'hCAFE_0001, 4'hF, 2, 0, 1);

    // Read-only status and unimplemented index
    do_read(6'h38, 0, 0);
    do_write(6'h38, 32'h1111_1111, 4'hF, 0, 0, 0);
    do_read(6'h38, 0, 0);
    do_read(6'h3C, 0, 0);
    do_write(6'h3C, 32'h2222_2222, 4'hF, 0, 0, 0);

    // Zero strobe still pulses; unaligned address ignores low bits
    do_write(6'h0C, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
    do_write(6'h06, 32'h0000_0077, 4'hF, 1, 1, 0);
    do_read(6'h05, 0, 0);

    // Back-pressure on B and R
    do_write(6'h10, 32'h5A5A_5A5A, 4'hF, 0, 0, 5);
    do_read(6'h10, 1, 4);

    // Reset while waiting in the write response state
    model_regs[1] = 32'h55;
    exp_p_q.push_back(4'd1);
    awaddr = 6'h04; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    hs_aw = 0; hs_w = 0;
    for (int c = 0; c < 20 && !(hs_aw && hs_w); c++) begin
      @(negedge clk);
      if (awvalid && awready) hs_aw = 1;
      if (wvalid && wready) hs_w = 1;
      @(posedge clk); #1;
      if (hs_aw) awvalid = 0;
      if (hs_w) wvalid = 0;
    end
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_test_bvalid_pending", 64'(bvalid), 64'(1));
    chk("rst_test_reg1_written", 64'(reg_out[63:32]), 64'(32'h55));
    #2 rst_n = 0;
    #1;
    clear_model();
    chk("rst_async_bvalid", 64'(bvalid), 64'(0));
    chk("rst_async_reg1", 64'(reg_out[63:32]), 64'(0));
    chk("rst_async_readys", 64'({awready, wready, arready}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1 chk("rel_readys_low", 64'({awready, wready, arready}), 64'(0));
    @(posedge clk); #1;
    chk("rel_readys_high", 64'({awready, wready, arready}), 64'(3'b111));
    chk("rel_no_b", 64'(bvalid), 64'(0));
    do_read(6'h04, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) status_in = {$urandom, $urandom};
      op = int'($urandom_range(0, 1));
      ad = int'($urandom_range(0, 63));
      aw_d = int'($urandom_range(0, 3));
      w_d = int'($urandom_range(0, 3));
      bd = int'($urandom_range(0, 3));
      if (op == 0) do_write(6'(ad), $urandom, 4'($urandom_range(0, 15)), aw_d, w_d, bd);
      else do_read(6'(ad), aw_d, bd);
    end

    // Final register view against the model
    @(negedge clk);
    for (int r = 0; r < NUM_REGS; r++) chk("final_reg_out", 64'(reg_out[r*32 +: 32]), 64'(model_slot(r)));
    chk("b_queue_empty", 64'(exp_b_q.size()), 64'(0));
    chk("r_queue_empty", 64'(exp_r_q.size()), 64'(0));
    chk("pulse_queue_empty", 64'(exp_p_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
